sev_seg_updater: RTL and testbench

SEV_SEG_UPDATER -- requirements
Module: sev_seg_updater

---
 rtl/sev_seg_updater.sv | 173 +++++++++++++++++
 tb/tb_sev_seg_updater.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sev_seg_updater.sv
// Encodes an eight-digit hex update into two active-low segment words and writes
// each word to its PIO register over Avalon-MM, skipping words that have not changed.
module sev_seg_updater #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] STRIDE    = 32'h10,
   parameter int unsigned TIMEOUT   = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [31:0] upd_value,
   input  logic [7:0]  upd_dp,
   input  logic [7:0]  upd_blank,
   input  logic        upd_force,
   output logic [31:0] avm_address,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        err,
   input  logic        err_clr
);
   typedef enum logic [1:0] {IDLE, WR0, WR1, DONE} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   function automatic logic [7:0] enc_digit(input logic [3:0] hex, input logic dp,
                                            input logic blank);
      logic [6:0] seg;
      seg = 7'h7F;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return blank ? 8'hFF : {~dp, seg};
   endfunction

   function automatic logic [31:0] enc_word(input logic [15:0] hex, input logic [3:0] dp,
                                            input logic [3:0] blank);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = enc_digit(hex[4*i +: 4], dp[i], blank[i]);
      return w;
   endfunction

   state_t           state_q, state_d;
   logic [1:0][31:0] word_q, word_d, shadow_q, shadow_d;
   logic [1:0][31:0] new_word;
   logic [1:0]       need_q, need_d, valid_q, valid_d;
   logic [15:0]      tcnt_q, tcnt_d;
   logic             err_q, err_d, wr_q, wr_d;
   logic [31:0]      addr_q, addr_d, data_q, data_d;
   logic             cur;

   assign new_word[0] = enc_word(upd_value[15:0],  upd_dp[3:0], upd_blank[3:0]);
   assign new_word[1] = enc_word(upd_value[31:16], upd_dp[7:4], upd_blank[7:4]);

   assign upd_ready      = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign err            = err_q;
   assign avm_write      = wr_q;
   assign avm_address    = addr_q;
   assign avm_writedata  = data_q;
   assign avm_byteenable = 4'hF;

   // The bus outputs are registered, so each write is launched on the edge that enters its state.
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      shadow_d = shadow_q;
      need_d   = need_q;
      valid_d  = valid_q;
      tcnt_d   = tcnt_q;
      err_d    = err_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      cur      = (state_q == WR1);
      if (err_clr) err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (upd_valid) begin
               word_d = new_word;
               for (int w = 0; w < 2; w++)
                  need_d[w] = upd_force | ~valid_q[w] | (shadow_q[w] != new_word[w]);
               state_d = WR0;
               if (need_d[0]) begin
                  wr_d   = 1'b1;
                  addr_d = BASE_ADDR;
                  data_d = new_word[0];
                  tcnt_d = '0;
               end
            end
         end
         WR0, WR1: begin
            if (wr_q && avm_waitrequest) begin
               tcnt_d = tcnt_q + 16'd1;
               if (tcnt_q == TMO_LAST) begin
                  wr_d         = 1'b0;
                  addr_d       = '0;
                  data_d       = '0;
                  err_d        = 1'b1;
                  valid_d[cur] = 1'b0;
                  state_d      = DONE;
               end
            end else begin
               if (wr_q) begin
                  shadow_d[cur] = word_q[cur];
                  valid_d[cur]  = 1'b1;
               end
               wr_d   = 1'b0;
               addr_d = '0;
               data_d = '0;
               if (state_q == WR0) begin
                  state_d = WR1;
                  if (need_q[1]) begin
                     wr_d   = 1'b1;
                     addr_d = BASE_ADDR + STRIDE;
                     data_d = word_q[1];
                     tcnt_d = '0;
                  end
               end else begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         word_q   <= '0;
         shadow_q <= '0;
         need_q   <= '0;
         valid_q  <= '0;
         tcnt_q   <= '0;
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         shadow_q <= shadow_d;
         need_q   <= need_d;
         valid_q  <= valid_d;
         tcnt_q   <= tcnt_d;
         err_q    <= err_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end
endmodule

// File: tb/tb_sev_seg_updater.sv
// Scoreboard bench for sev_seg_updater: a digit-table model predicts each bus write,
// and a monitor checks every completed or timed-out write against that prediction.
`timescale 1ns/1ps
module tb_sev_seg_updater;
   localparam logic [31:0] BASE   = 32'h0000_2000;
   localparam logic [31:0] STRIDE = 32'h10;
   localparam int          TMO    = 6;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [31:0] upd_value = '0;
   logic [7:0]  upd_dp = '0;
   logic [7:0]  upd_blank = '0;
   logic        upd_force = 1'b0;
   logic [31:0] avm_address;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest = 1'b0;
   logic        busy;
   logic        err;
   logic        err_clr = 1'b0;

   sev_seg_updater #(.BASE_ADDR(BASE), .STRIDE(STRIDE), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_value(upd_value), .upd_dp(upd_dp), .upd_blank(upd_blank), .upd_force(upd_force),
      .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
      .busy(busy), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cycles;
      bit          timeout;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [31:0] m_shadow [2];
   bit          m_valid [2];
   bit          m_err;
   int          next_stall = 0;
   bit          wr_stuck = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [31:0] value, input logic [7:0] dp,
                                              input logic [7:0] blank, input int w);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         int         d;
         logic [7:0] b;
         d = 4 * w + k;
         if (blank[d]) b = 8'hFF;
         else begin
            b = hex_tab[value[4*d +: 4]];
            if (dp[d]) b[7] = 1'b0;
         end
         r[8*k +: 8] = b;
      end
      return r;
   endfunction

   // Predicts which words get written and for how long the FSM stays busy.
   task automatic model_request(input logic [31:0] value, input logic [7:0] dp, input logic [7:0] blank,
                                input bit frc, input int stall, input bit stuck, output int busy_exp);
      bit aborted;
      aborted = 1'b0;
      busy_exp = 1;
      for (int w = 0; w < 2; w++) begin
         logic [31:0] word;
         exp_t        e;
         word = model_word(value, dp, blank, w);
         if (!aborted) begin
            if (frc || !m_valid[w] || m_shadow[w] != word) begin
               e.addr = BASE + STRIDE * w;
               e.data = word;
               if (stuck) begin
                  e.cycles = TMO; e.timeout = 1'b1;
                  m_valid[w] = 1'b0; m_err = 1'b1; aborted = 1'b1;
                  busy_exp += TMO;
               end else begin
                  e.cycles = stall + 1; e.timeout = 1'b0;
                  m_shadow[w] = word; m_valid[w] = 1'b1;
                  busy_exp += stall + 1;
               end
               exp_q.push_back(e);
            end else begin
               busy_exp += 1;
            end
         end
      end
   endtask

   task automatic drive_request(input logic [31:0] value, input logic [7:0] dp, input logic [7:0] blank,
                                input bit frc);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!upd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check_output("ready_wait", 32'(upd_ready), 32'd1);
      upd_valid = 1'b1; upd_value = value; upd_dp = dp; upd_blank = blank; upd_force = frc;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      upd_value = $urandom; upd_dp = 8'($urandom); upd_blank = 8'($urandom);
      upd_force = 1'($urandom);
   endtask

   task automatic apply_stimulus(input string name, input logic [31:0] value, input logic [7:0] dp,
                                 input logic [7:0] blank, input bit frc, input int stall, input bit stuck);
      int busy_exp, busy_cnt;
      busy_cnt = 0;
      next_stall = stall;
      wr_stuck = stuck;
      model_request(value, dp, blank, frc, stall, stuck, busy_exp);
      drive_request(value, dp, blank, frc);
      @(negedge clk);
      while (busy && busy_cnt < 200) begin
         busy_cnt++;
         @(negedge clk);
      end
      check_output({name, "_busy_cycles"}, 32'(busy_cnt), 32'(busy_exp));
      check_output({name, "_ready"}, 32'(upd_ready), 32'd1);
      check_output({name, "_err"}, 32'(err), 32'(m_err));
      wr_stuck = 1'b0;
   endtask

   // Slave model: stalls each new write for next_stall cycles, or forever while wr_stuck.
   bit in_write = 1'b0;
   int stall_left = 0;
   always @(posedge clk) begin
      #1;
      if (!reset_n) begin
         in_write = 1'b0;
         avm_waitrequest = 1'b0;
      end else if (wr_stuck) begin
         in_write = 1'b0;
         avm_waitrequest = 1'b1;
      end else begin
         if (in_write) begin
            if (!avm_waitrequest) in_write = 1'b0;
            else stall_left--;
         end
         if (!in_write && avm_write) begin
            in_write = 1'b1;
            stall_left = next_stall;
         end
         avm_waitrequest = in_write && (stall_left > 0);
      end
   end

   int          run = 0;
   logic [31:0] prev_a = '0, prev_d = '0;

   task automatic score(input bit aborted);
      exp_t e;
      if (exp_q.size() == 0) begin
         check_output("unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check_output("wr_addr", prev_a, e.addr);
         check_output("wr_data", prev_d, e.data);
         check_output("wr_cycles", 32'(run), 32'(e.cycles));
         check_output("wr_timeout", 32'(aborted), 32'(e.timeout));
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         run = 0;
      end else if (avm_write) begin
         run++;
         if (run > 1) begin
            check_output("hold_addr", avm_address, prev_a);
            check_output("hold_data", avm_writedata, prev_d);
         end
         check_output("byteenable", 32'(avm_byteenable), 32'hF);
         prev_a = avm_address;
         prev_d = avm_writedata;
         if (!avm_waitrequest) begin
            score(1'b0);
            run = 0;
         end
      end else begin
         if (run > 0) score(1'b1);
         run = 0;
         check_output("idle_addr", avm_address, 32'd0);
         check_output("idle_data", avm_writedata, 32'd0);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      logic [7:0]  dp, bl;
      m_shadow[0] = '0; m_shadow[1] = '0;
      m_valid[0] = 1'b0; m_valid[1] = 1'b0;
      m_err = 1'b0;

      #12;
      check_output("rst_write", 32'(avm_write), 32'd0);
      check_output("rst_addr", avm_address, 32'd0);
      check_output("rst_data", avm_writedata, 32'd0);
      check_output("rst_err", 32'(err), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_output("rst_ready", 32'(upd_ready), 32'd1);

      apply_stimulus("basic", 32'h0000_0123, 8'h00, 8'h00, 1'b0, 0, 1'b0);
      apply_stimulus("skip", 32'h0000_0123, 8'h00, 8'h00, 1'b0, 0, 1'b0);
      apply_stimulus("force", 32'h0000_0123, 8'h00, 8'h00, 1'b1, 0, 1'b0);
      apply_stimulus("stall_dp_blank", 32'h0000_0123, 8'h01, 8'hF0, 1'b0, TMO - 1, 1'b0);
      apply_stimulus("timeout", 32'h0000_0123, 8'h01, 8'hF0, 1'b1, 0, 1'b1);
      apply_stimulus("retry", 32'h0000_0123, 8'h01, 8'hF0, 1'b0, 0, 1'b0);

      @(negedge clk);
      err_clr = 1'b1;
      m_err = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      check_output("err_clr", 32'(err), 32'(m_err));

      v = 32'h89AB_CDEF; dp = 8'h00; bl = 8'h00;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: ;
            1: v[15:0] = 16'($urandom);
            default: v = $urandom;
         endcase
         if ($urandom_range(0, 2) == 0) begin
            dp = 8'($urandom & $urandom);
            bl = 8'($urandom & $urandom & $urandom);
         end
         apply_stimulus("rand", v, dp, bl, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b0);
      end

      wr_stuck = 1'b1;
      drive_request(32'h0000_0123, 8'h00, 8'h00, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_output("reset_abort_write", 32'(avm_write), 32'd0);
      check_output("reset_abort_busy", 32'(busy), 32'd0);
      exp_q.delete();
      m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_err = 1'b0;
      wr_stuck = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_output("ready_after_reset", 32'(upd_ready), 32'd1);
      apply_stimulus("after_reset", 32'h0000_0123, 8'h00, 8'h00, 1'b0, 0, 1'b0);

      repeat (3) @(negedge clk);
      check_output("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
